phase_gen: RTL and testbench

Multicycle phase sequencer for the `micro` core. It drives the one-hot `phase` bus consumed by the pc and memory stages. That bus has five phases: fetch F, register read R, execute X, memory M and writeback W. The sequencer stalls F and M on memory acknowledge, and provides halt, run and single-step control. It also keeps free-running cycle and retired-instruction counters for debug.

---
 rtl/phase_gen.sv | 109 ++++++++++
 tb/tb_phase_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/phase_gen.sv
// Multicycle F/R/X/M/W phase sequencer with halt, run and single-step control,
// plus free-running cycle and retired-instruction debug counters.
module phase_gen #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ready,
  input  logic             mem_op,
  input  logic             halt_req,
  input  logic             run,
  input  logic             step,
  output logic [4:0]       phase,
  output logic             halted,
  output logic             phase_adv,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] StFetch = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StExec  = 3'd2;
  localparam logic [2:0] StMem   = 3'd3;
  localparam logic [2:0] StWb    = 3'd4;
  localparam logic [2:0] StHalt  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             halt_pend_q, halt_pend_d;
  logic             step_mode_q, step_mode_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             enter_halt;
  logic             leave_halt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (mem_ready) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StMem;
      StMem:   if (!mem_op || mem_ready) state_d = StWb;
      // A halt request arriving in W itself still stops at this boundary.
      StWb:    state_d = (halt_pend_q || halt_req || step_mode_q) ? StHalt : StFetch;
      StHalt:  if (run || step) state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  assign enter_halt = (state_q == StWb) && (state_d == StHalt);
  assign leave_halt = (state_q == StHalt) && (run || step);

  always_comb begin
    halt_pend_d = halt_pend_q;
    if (enter_halt) begin
      halt_pend_d = 1'b0;
    end else if (halt_req && (state_q != StHalt)) begin
      halt_pend_d = 1'b1;
    end
  end

  // run has priority over step when both are presented in HALT.
  always_comb begin
    step_mode_d = step_mode_q;
    if (leave_halt) step_mode_d = !run;
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != StHalt) cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (state_q == StWb)   instr_cnt_d = instr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      halt_pend_q <= 1'b0;
      step_mode_q <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      step_mode_q <= step_mode_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    phase = 5'b00000;
    unique case (state_q)
      StFetch: phase = 5'b10000;
      StRead:  phase = 5'b01000;
      StExec:  phase = 5'b00100;
      StMem:   phase = 5'b00010;
      StWb:    phase = 5'b00001;
      default: phase = 5'b00000;
    endcase
  end

  assign halted    = (state_q == StHalt);
  assign retire    = (state_q == StWb);
  assign phase_adv = (state_d != state_q);
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_phase_gen.sv
// Self-checking bench for phase_gen: directed scenarios plus random traffic,
// all checked every cycle against a position-based reference model.
module tb_phase_gen;

  logic        clk = 1'b0;
  logic        rst, mem_ready, mem_op, halt_req, run, step;
  logic [4:0]  phase, phase4;
  logic        halted, phase_adv, retire;
  logic        halted4, phase_adv4, retire4;
  logic [31:0] cycle_cnt, instr_cnt;
  logic [3:0]  cycle_cnt4, instr_cnt4;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model: pos 0..4 is the position within F,R,X,M,W; 5 means HALT.
  int          m_pos;
  bit          m_pend, m_stepm;
  int unsigned m_cyc, m_ins;

  always #5 clk = ~clk;

  phase_gen #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .mem_op(mem_op), .halt_req(halt_req),
    .run(run), .step(step), .phase(phase), .halted(halted), .phase_adv(phase_adv),
    .retire(retire), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  phase_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .mem_op(mem_op), .halt_req(halt_req),
    .run(run), .step(step), .phase(phase4), .halted(halted4), .phase_adv(phase_adv4),
    .retire(retire4), .cycle_cnt(cycle_cnt4), .instr_cnt(instr_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next();
    bit stall;
    if (m_pos == 5) return (run || step) ? 0 : 5;
    if (m_pos == 4) return (m_pend || halt_req || m_stepm) ? 5 : 0;
    stall = (m_pos == 0 && !mem_ready) || (m_pos == 3 && mem_op && !mem_ready);
    return stall ? m_pos : m_pos + 1;
  endfunction

  task automatic check_outputs();
    logic [4:0] exp_phase;
    exp_phase = (m_pos == 5) ? 5'b00000 : (5'b10000 >> m_pos);
    chk("phase", 32'(phase), 32'(exp_phase));
    chk("halted", 32'(halted), 32'(m_pos == 5));
    chk("retire", 32'(retire), 32'(m_pos == 4));
    chk("phase_adv", 32'(phase_adv), 32'(model_next() != m_pos));
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instr_cnt", instr_cnt, m_ins);
    chk("cycle_cnt4", 32'(cycle_cnt4), m_cyc % 16);
    chk("instr_cnt4", 32'(instr_cnt4), m_ins % 16);
  endtask

  // Inputs are driven 1 time unit after posedge; checks happen at the negedge.
  task automatic tick();
    int nxt;
    #4;
    check_outputs();
    @(posedge clk);
    if (rst) begin
      m_pos = 0; m_pend = 0; m_stepm = 0; m_cyc = 0; m_ins = 0;
    end else begin
      nxt = model_next();
      if (m_pos != 5) m_cyc++;
      if (m_pos == 4) m_ins++;
      if (m_pos == 5 && (run || step)) m_stepm = !run;
      if (m_pos == 4 && nxt == 5) m_pend = 0;
      else if (halt_req && m_pos != 5) m_pend = 1;
      m_pos = nxt;
    end
    #1;
  endtask

  task automatic idle_inputs();
    mem_ready = 1'b1; mem_op = 1'b0; halt_req = 1'b0; run = 1'b0; step = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m_pos = 0; m_pend = 0; m_stepm = 0; m_cyc = 0; m_ins = 0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back instructions with no stalls.
    chk("reset_phase", 32'(phase), 32'h10);
    chk("reset_cycle", cycle_cnt, 0);
    repeat (10) tick();
    chk("tp1_instr", instr_cnt, 2);
    chk("tp1_cycle", cycle_cnt, 10);
    chk("tp1_phase", 32'(phase), 32'h10);

    // Stalls in F and in M.
    do_reset();
    mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1; tick();
    tick(); tick();
    mem_op = 1'b1; mem_ready = 1'b0;
    repeat (2) tick();
    mem_ready = 1'b1; tick();
    mem_op = 1'b0; tick();
    chk("tp2_cycle", cycle_cnt, 10);
    chk("tp2_instr", instr_cnt, 1);

    // Halt requested in R completes the instruction, then idles.
    do_reset();
    tick();
    halt_req = 1'b1; tick();
    halt_req = 1'b0;
    repeat (3) tick();
    chk("tp3_halted", 32'(halted), 1);
    chk("tp3_phase", 32'(phase), 0);
    repeat (20) tick();
    chk("tp3_cycle_frozen", cycle_cnt, 5);
    chk("tp3_instr", instr_cnt, 1);

    // Single step, then run+step together runs continuously.
    step = 1'b1; tick();
    step = 1'b0;
    repeat (5) tick();
    chk("tp4_step_halted", 32'(halted), 1);
    chk("tp4_step_instr", instr_cnt, 2);
    run = 1'b1; step = 1'b1; tick();
    run = 1'b0; step = 1'b0;
    repeat (6) tick();
    chk("tp4_run_not_halted", 32'(halted), 0);
    repeat (8) tick();
    chk("tp4_run_instr", instr_cnt, 4);

    // Reset during X clears counters and a latched halt request.
    do_reset();
    repeat (5) tick();
    halt_req = 1'b1; tick();
    halt_req = 1'b0; tick();
    chk("tp5_pre_cycle", cycle_cnt, 7);
    chk("tp5_pre_phase", 32'(phase), 32'h04);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("tp5_phase", 32'(phase), 32'h10);
    chk("tp5_cycle", cycle_cnt, 0);
    repeat (6) tick();
    chk("tp5_not_halted", 32'(halted), 0);

    // Narrow counters wrap.
    do_reset();
    repeat (85) tick();
    chk("tp6_instr4", 32'(instr_cnt4), 1);
    chk("tp6_cycle4", 32'(cycle_cnt4), 5);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      mem_ready = ($urandom_range(0, 9) < 7);
      mem_op    = $urandom_range(0, 1);
      halt_req  = ($urandom_range(0, 29) == 0);
      run       = ($urandom_range(0, 5) == 0);
      step      = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
